chan_err_inject: RTL
====================

# chan_err_inject

Registered channel-impairment stage between the convolutional encoder and the Viterbi decoder. Takes each valid 2-bit encoder symbol, XORs it with an error mask chosen by a run-time mode (off, periodic single-bit, pseudo-random, periodic burst), and presents the result one cycle later to the decoder with an aligned valid. It keeps saturating word and injected-bit counters so the bench can check decoder correction capability against the exact number of bits corrupted.

## Interface
- N, 4: rate exponent; trigger when a 2^N-word phase condition is met
- WINDOW, 256: injection allowed only while word_ct < WINDOW
- BURST_LEN, 3: words corrupted per burst, 1..15
- SEED, 16'hACE1: LFSR reset/clear value; 0 is replaced by 16'h0001
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- clear_i  in  1  synchronous clear of counters, LFSR, FSM
- mode_i  in  2  0 off, 1 periodic, 2 random, 3 burst
- valid_i  in  1  d_i carries an encoder symbol this cycle
- d_i  in  2  encoder symbol
- valid_o  out  1  d_o valid (valid_i delayed 1)
- d_o  out  2  d_i ^ mask, registered
- err_o  out  2  mask applied to d_o (diagnostic)
- word_ct_o  out  16  valid words accepted, saturating
- err_bit_ct_o  out  16  total mask bits applied, saturating

## Operation
- Per accepted word (valid_i=1, clear_i=0), w = word_ct before increment; inj_ok = (w < WINDOW).
- Mode 0: mask 2'b00.
- Mode 1: mask 2'b01 when inj_ok and w[N-1:0] == all ones.
- Mode 2: 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, advances once per accepted word (all modes). Inject when inj_ok and lfsr[N-1:0]==0, using the pre-advance value; mask = lfsr[N] ? 2'b10 : 2'b01.
- Mode 3, FSM IDLE/BURST with 4-bit burst_cnt:
  - IDLE: on periodic trigger (mode-1 condition), mask 2'b11. If BURST_LEN>1, go BURST with burst_cnt=BURST_LEN-1.
  - BURST: each accepted word gets mask 2'b11 if inj_ok, and burst_cnt decrements; at 1 return to IDLE.
  - A word with inj_ok=0 in BURST gets mask 0 and forces IDLE (window truncates the burst).
  - Idle cycles (valid_i=0) hold the state.
- mode_i is sampled per word. FSM is forced IDLE whenever mode_i != 3.
- Non-accepted cycles: d_o and err_o still register d_i with mask 0. Counters, LFSR and FSM hold.
- clear_i has priority over valid_i: that word is not counted, gets mask 0, LFSR = SEED, FSM IDLE, counters 0.
- Counter updates:
  - word_ct += 1 per accepted word.
  - err_bit_ct += popcount(mask).
  - Both saturate at 16'hFFFF; no wrap.

## Timing
- Reset values: valid_o 0, d_o 0, err_o 0, word_ct_o 0, err_bit_ct_o 0, LFSR SEED, FSM IDLE.
- Latency exactly 1 cycle d_i->d_o; valid_o, err_o aligned with d_o. Counters reflect a word in the same cycle its d_o appears.
- No backpressure; one word per cycle sustained.
- rst mid-burst clears immediately (async), restarts at w=0.

## Structure
- Package chan_err_pkg holds:
  - mode enum (MODE_OFF, MODE_PERIODIC, MODE_RANDOM, MODE_BURST)
  - FSM state enum (ST_IDLE, ST_BURST)
  - LFSR tap constant 16'hB400
  - saturating-add width constant
- Sub-module lfsr16 (clk, rst, clear, step, seed, q) is instantiated once.

## Test plan
- mode 0, 300 words d_i=2'b10: d_o=2'b10 one cycle after each valid_i; err_bit_ct_o=0, word_ct_o=300.
- mode 1, N=4, 300 words: err_o=2'b01 at w=15,31,…,255 only; final err_bit_ct_o=16.
- mode 3, BURST_LEN=3, 40 words: err_o=2'b11 at w=15,16,17,31,32,33; err_bit_ct_o=12.
- mode 3, WINDOW=256, trigger at w=255: only w=255 is corrupted, w=256 is clean, FSM IDLE; word_ct_o=257 after 257 words.
- mode 2: masks match a bit-exact LFSR model over 1000 words. Pulse clear_i at word 500: counters go to 0 and the mask sequence restarts identically to word 0.
- mode 3, valid_i every other cycle with rst low during BURST: the burst spans the gaps; on rst, all outputs go to 0 immediately and the first trigger after release is at w=15.

Source files
------------

// File: rtl/chan_err_pkg.sv
// Shared types and constants for the channel error-injection stage.
// Holds the mode/state enums, LFSR taps and the saturating counter helper.
package chan_err_pkg;

    typedef enum logic [1:0] {
        MODE_OFF      = 2'd0,
        MODE_PERIODIC = 2'd1,
        MODE_RANDOM   = 2'd2,
        MODE_BURST    = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    // Galois form of x^16+x^14+x^13+x^11+1 for a right-shifting register
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int unsigned CNT_W = 16;

    // Add a small increment, clamping at all ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [1:0]       b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W+1)'(b);
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR that steps once per enabled cycle.
// A zero seed would lock the register, so it is replaced by 16'h0001.
module lfsr16
    import chan_err_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        step,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] r_q;
    logic [15:0] w_seed;
    logic [15:0] w_next;

    assign w_seed = (seed == 16'h0000) ? 16'h0001 : seed;
    assign w_next = r_q[0] ? ((r_q >> 1) ^ LFSR_TAPS) : (r_q >> 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= w_seed;
        end else if (clear) begin
            r_q <= w_seed;
        end else if (step) begin
            r_q <= w_next;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/chan_err_inject.sv
// Channel-impairment stage: XORs each accepted 2-bit symbol with a mode-selected
// error mask, registers the result, and keeps saturating word/error-bit counters.
module chan_err_inject
    import chan_err_pkg::*;
#(
    parameter int unsigned N         = 4,
    parameter int unsigned WINDOW    = 256,
    parameter int unsigned BURST_LEN = 3,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic [1:0]  mode_i,
    input  logic        valid_i,
    input  logic [1:0]  d_i,
    output logic        valid_o,
    output logic [1:0]  d_o,
    output logic [1:0]  err_o,
    output logic [15:0] word_ct_o,
    output logic [15:0] err_bit_ct_o
);

    localparam logic [15:0] PER_MASK   = 16'((32'd1 << N) - 32'd1);
    localparam logic [3:0]  BURST_INIT = 4'(BURST_LEN - 1);

    logic             r_valid;
    logic [1:0]       r_d;
    logic [1:0]       r_err;
    logic [CNT_W-1:0] r_word_ct;
    logic [CNT_W-1:0] r_err_bit_ct;
    state_e           r_state;
    logic [3:0]       r_burst_cnt;

    state_e      w_state_nxt;
    logic [3:0]  w_burst_cnt_nxt;
    logic [1:0]  w_mask;
    logic [1:0]  w_mask_bits;
    logic        w_accept;
    logic        w_inj_ok;
    logic        w_periodic;
    logic        w_rand_hit;
    logic [15:0] w_lfsr;
    mode_e       w_mode;

    assign w_mode      = mode_e'(mode_i);
    assign w_accept    = valid_i & ~clear_i;
    assign w_inj_ok    = (32'(r_word_ct) < WINDOW);
    assign w_periodic  = w_inj_ok && ((r_word_ct & PER_MASK) == PER_MASK);
    assign w_rand_hit  = w_inj_ok && ((w_lfsr & PER_MASK) == 16'h0000);
    assign w_mask_bits = 2'({1'b0, w_mask[1]} + {1'b0, w_mask[0]});

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .clear (clear_i),
        .step  (w_accept),
        .seed  (SEED),
        .q     (w_lfsr)
    );

    // Burst FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_burst_cnt <= 4'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
        end
    end

    // Burst FSM next state; idle cycles hold, a closed window truncates the burst
    always_comb begin
        w_state_nxt     = r_state;
        w_burst_cnt_nxt = r_burst_cnt;
        if (clear_i || (w_mode != MODE_BURST)) begin
            w_state_nxt = ST_IDLE;
        end else if (valid_i) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_periodic && (BURST_LEN > 1)) begin
                        w_state_nxt     = ST_BURST;
                        w_burst_cnt_nxt = BURST_INIT;
                    end
                end
                ST_BURST: begin
                    if (!w_inj_ok || (r_burst_cnt <= 4'd1)) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_burst_cnt_nxt = r_burst_cnt - 4'd1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Error mask for the current word
    always_comb begin
        w_mask = 2'b00;
        if (w_accept) begin
            case (w_mode)
                MODE_PERIODIC: if (w_periodic) w_mask = 2'b01;
                MODE_RANDOM:   if (w_rand_hit) w_mask = w_lfsr[N] ? 2'b10 : 2'b01;
                MODE_BURST: begin
                    if (r_state == ST_BURST) begin
                        if (w_inj_ok) w_mask = 2'b11;
                    end else if (w_periodic) begin
                        w_mask = 2'b11;
                    end
                end
                default: w_mask = 2'b00;
            endcase
        end
    end

    // Output datapath and counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid      <= 1'b0;
            r_d          <= 2'b00;
            r_err        <= 2'b00;
            r_word_ct    <= '0;
            r_err_bit_ct <= '0;
        end else begin
            r_valid <= valid_i;
            r_d     <= d_i ^ w_mask;
            r_err   <= w_mask;
            if (clear_i) begin
                r_word_ct    <= '0;
                r_err_bit_ct <= '0;
            end else if (w_accept) begin
                r_word_ct    <= sat_add(r_word_ct, 2'd1);
                r_err_bit_ct <= sat_add(r_err_bit_ct, w_mask_bits);
            end
        end
    end

    assign valid_o      = r_valid;
    assign d_o          = r_d;
    assign err_o        = r_err;
    assign word_ct_o    = r_word_ct;
    assign err_bit_ct_o = r_err_bit_ct;

endmodule
